// File: rtl/sumador_rizado_secuenciador_pkg.sv
// Shared definitions for the ripple-adder sequencing stage: FSM state
// encodings, the byte width and the bit-reverse helper used to straighten
// the adder's sum bus.
package sumador_rizado_secuenciador_pkg;

    localparam int unsigned SUM_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Mirror a byte: bit i moves to bit SUM_W-1-i.
    function automatic logic [SUM_W-1:0] bitrev8(input logic [SUM_W-1:0] v);
        logic [SUM_W-1:0] r;
        r = '0;
        for (int i = 0; i < SUM_W; i++) begin
            r[i] = v[SUM_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sumador_rizado_secuenciador_if.sv
// Bundle of the operand handshake, the adder connection and the result
// handshake. The "slave" side is the sequencer; the "master" side is the
// parent that owns the operand source, the ripple adder and the consumer.
interface sumador_rizado_secuenciador_if;
    import sumador_rizado_secuenciador_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_a;
    logic [SUM_W-1:0] in_b;
    logic             in_cin;
    logic             in_first;
    logic             in_last;

    logic [SUM_W-1:0] add_a;
    logic [SUM_W-1:0] add_b;
    logic             add_ci;
    logic [SUM_W-1:0] add_s;
    logic             add_co;

    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             out_co;
    logic             out_last;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_first, in_last, out_ready, add_s, add_co,
        input  in_ready, add_a, add_b, add_ci, out_valid, out_sum, out_co, out_last, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_first, in_last, out_ready, add_s, add_co,
        output in_ready, add_a, add_b, add_ci, out_valid, out_sum, out_co, out_last, out_ovf
    );

endinterface

// File: rtl/sumador_rizado_secuenciador.sv
// Sequencer around an external 8-bit ripple adder. Operand bytes are
// registered on accept and drive the adder; one settle cycle later the sum
// and carry are captured into the result register. Byte beats chain into
// wider additions by carrying each beat's carry-out into the next beat.
// Optional build macro: SUM_RIZADO_OVF_EN enables signed-overflow capture on
// out_ovf; without it out_ovf is tied low.
module sumador_rizado_secuenciador
    import sumador_rizado_secuenciador_pkg::*;
#(
    parameter int PwrC       = 0,
    parameter bit SUM_BITREV = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset_L,
    sumador_rizado_secuenciador_if.slave       sec_io
);

    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] add_a_q, add_b_q;
    logic             add_ci_q;
    logic             last_q;
    logic             carry_q;
    logic [SUM_W-1:0] out_sum_q;
    logic             out_co_q;
    logic             out_last_q;

    logic             in_ready;
    logic             accept;
    logic             capture;
    logic [SUM_W-1:0] sum_corr;

    // Power-class tag only travels with the netlist; it drives nothing.
    logic unused_pwrc;
    assign unused_pwrc = ^PwrC;

    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & sec_io.out_ready);
    assign accept   = sec_io.in_valid & in_ready;
    assign capture  = (state_q == ST_ISSUE);
    assign sum_corr = SUM_BITREV ? bitrev8(sec_io.add_s) : sec_io.add_s;

    // Next-state: IDLE -> ISSUE on accept, ISSUE always settles into HOLD,
    // HOLD drains on out_ready and may take the next beat in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (sec_io.out_ready) state_d = accept ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers load only on accept so the adder inputs stay quiet.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_ci_q <= 1'b0;
            last_q   <= 1'b0;
        end else if (accept) begin
            add_a_q  <= sec_io.in_a;
            add_b_q  <= sec_io.in_b;
            add_ci_q <= sec_io.in_first ? sec_io.in_cin : carry_q;
            last_q   <= sec_io.in_last;
        end
    end

    // Result capture after the settle cycle; the final beat's carry is not chained.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_sum_q  <= '0;
            out_co_q   <= 1'b0;
            out_last_q <= 1'b0;
            carry_q    <= 1'b0;
        end else if (capture) begin
            out_sum_q  <= sum_corr;
            out_co_q   <= sec_io.add_co;
            out_last_q <= last_q;
            carry_q    <= last_q ? 1'b0 : sec_io.add_co;
        end
    end

`ifdef SUM_RIZADO_OVF_EN
    logic out_ovf_q;
    logic ovf_d;

    // Signed overflow: operands agree in sign and the corrected sum does not.
    assign ovf_d = (add_a_q[SUM_W-1] ~^ add_b_q[SUM_W-1]) & (add_a_q[SUM_W-1] ^ sum_corr[SUM_W-1]);

    // Overflow flag captured alongside the sum.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_ovf_q <= 1'b0;
        end else if (capture) begin
            out_ovf_q <= ovf_d;
        end
    end

    assign sec_io.out_ovf = out_ovf_q;
`else
    assign sec_io.out_ovf = 1'b0;
`endif

    assign sec_io.in_ready  = in_ready;
    assign sec_io.add_a     = add_a_q;
    assign sec_io.add_b     = add_b_q;
    assign sec_io.add_ci    = add_ci_q;
    assign sec_io.out_valid = (state_q == ST_HOLD);
    assign sec_io.out_sum   = out_sum_q;
    assign sec_io.out_co    = out_co_q;
    assign sec_io.out_last  = out_last_q;

endmodule

// File: tb/tb_sumador_rizado_secuenciador.sv
// Directed bench for the ripple-adder sequencer. A behavioural ripple adder
// with a bit-reversed sum bus stands in for the real adder.
module tb_sumador_rizado_secuenciador;

    logic clk;
    logic reset_L;

    sumador_rizado_secuenciador_if bus ();

    sumador_rizado_secuenciador #(
        .PwrC       (0),
        .SUM_BITREV (1'b1)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .sec_io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: true sum delivered with its bits mirrored.
    logic [8:0] raw;
    always_comb begin
        raw = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_ci};
        for (int i = 0; i < 8; i++) bus.add_s[i] = raw[7-i];
        bus.add_co = raw[8];
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       first;
        logic       last;
        logic       ci;
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } vec_t;

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ovf(input string name, input logic exp);
`ifdef SUM_RIZADO_OVF_EN
        chk(name, {31'd0, bus.out_ovf}, {31'd0, exp});
`else
        chk(name, {31'd0, bus.out_ovf}, {31'd0, 1'b0 & exp});
`endif
    endtask

    // Full beat from IDLE: accept, settle, check result, drain back to IDLE.
    task automatic do_beat(input string tag, input vec_t v);
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_cin   = v.cin;
        bus.in_first = v.first;
        bus.in_last  = v.last;
        bus.in_valid = 1'b1;
        chk({tag, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, " add_a"}, {24'd0, bus.add_a}, {24'd0, v.a});
        chk({tag, " add_b"}, {24'd0, bus.add_b}, {24'd0, v.b});
        chk({tag, " add_ci"}, {31'd0, bus.add_ci}, {31'd0, v.ci});
        chk({tag, " issue out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " issue in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        step();
        chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, " out_sum"}, {24'd0, bus.out_sum}, {24'd0, v.sum});
        chk({tag, " out_co"}, {31'd0, bus.out_co}, {31'd0, v.co});
        chk({tag, " out_last"}, {31'd0, bus.out_last}, {31'd0, v.last});
        chk_ovf({tag, " out_ovf"}, v.ovf);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, " drained out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    vec_t vecs[13];
    vec_t v;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //                 a      b      cin   first last  ci    sum    co    ovf
        vecs[0]  = {8'h3C, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1]  = {8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = {8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[3]  = {8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[4]  = {8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[5]  = {8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6]  = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = {8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[8]  = {8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9]  = {8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b0};
        vecs[10] = {8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[11] = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[12] = {8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_cin    = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        reset_L       = 1'b0;

        // Reset state.
        step();
        step();
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst add_a", {24'd0, bus.add_a}, 32'd0);
        chk("rst add_b", {24'd0, bus.add_b}, 32'd0);
        chk("rst add_ci", {31'd0, bus.add_ci}, 32'd0);
        chk("rst out_sum", {24'd0, bus.out_sum}, 32'd0);
        chk("rst out_co", {31'd0, bus.out_co}, 32'd0);
        chk("rst out_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        reset_L = 1'b1;
        step();

        // Table: standalone adds, 16/24-bit chains, first overriding carry,
        // last-beat carry not chained, bit order, overflow.
        for (int i = 0; i < 13; i++) begin
            do_beat($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held while out_ready is low, next beat waits.
        do_beat("bp_pre", vecs[0]);
        bus.in_a = 8'h3C; bus.in_b = 8'h0F; bus.in_cin = 1'b0;
        bus.in_first = 1'b1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.in_a = 8'h11; bus.in_b = 8'h22;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp hold out_valid %0d", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp hold out_sum %0d", k), {24'd0, bus.out_sum}, 32'h4B);
            chk($sformatf("bp hold in_ready %0d", k), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("bp hold add_a %0d", k), {24'd0, bus.add_a}, 32'h3C);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp new add_a", {24'd0, bus.add_a}, 32'h11);
        chk("bp new issue out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("bp new out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp new out_sum", {24'd0, bus.out_sum}, 32'h33);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Reset mid-chain: leave carry_q=1, then reset during ISSUE of the next beat.
        do_beat("rc_b1", vecs[1]);
        bus.in_a = 8'hFF; bus.in_b = 8'h01; bus.in_cin = 1'b0;
        bus.in_first = 1'b0; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("rc issue add_ci", {31'd0, bus.add_ci}, 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("rc async out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rc async in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rc async add_a", {24'd0, bus.add_a}, 32'd0);
        step();
        chk("rc held out_valid", {31'd0, bus.out_valid}, 32'd0);
        reset_L = 1'b1;
        step();
        v = {8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        do_beat("rc_after", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sumador_rizado_secuenciador.md
Name: sumador_rizado_secuenciador

Overview:
- Sequencing stage that wraps the 8-bit ripple adder: feeds its a/b/ci inputs from registered operands and captures its s/co outputs into a result register.
- Chains byte beats into multi-byte additions by feeding each beat's carry-out into the next beat's carry-in.
- Valid/ready handshakes on both sides.
- Operand registers load only on accept, so adder inputs do not toggle while idle; this keeps power-analysis runs clean.

Parameters:
- PwrC, 0, power-class tag carried for the power flow; no functional effect.
- SUM_BITREV, 1, 1 = the adder's s bus arrives bit-reversed (adder s[7] is true bit 0); the block un-reverses before capture. 0 = straight.

Ports:
- clk  in  1  clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  8  operand A byte
- in_b  in  8  operand B byte
- in_cin  in  1  carry-in used only on a first beat
- in_first  in  1  beat is the least-significant byte of a new operation
- in_last  in  1  beat is the most-significant byte
- add_a  out  8  to adder a
- add_b  out  8  to adder b
- add_ci  out  1  to adder ci
- add_s  in  8  from adder s
- add_co  in  1  from adder co
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_sum  out  8  corrected sum byte
- out_co  out  1  carry-out of this beat
- out_last  out  1  copy of in_last for this beat
- out_ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Reset values (asserted asynchronously): state=IDLE; every register 0, i.e. add_a, add_b, add_ci, out_sum, out_co, out_last, out_ovf, out_valid = 0 and carry_q = 0.
- FSM states are IDLE, ISSUE and HOLD.
  - IDLE: in_ready=1. Accept (in_valid & in_ready) loads add_a<=in_a, add_b<=in_b, add_ci<=(in_first ? in_cin : carry_q), last_q<=in_last, then goes to ISSUE.
  - ISSUE: in_ready=0, out_valid=0. This is one settle cycle for the combinational adder. At the edge: out_sum <= SUM_BITREV ? reverse(add_s) : add_s; out_co <= add_co; out_last <= last_q; carry_q <= last_q ? 0 : add_co. Then goes to HOLD.
  - HOLD: out_valid=1 and outputs are held stable. On out_ready: if in_valid, accept a new beat exactly as in IDLE and go to ISSUE; otherwise go to IDLE.
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
- Latency: accept at edge N puts out_valid high after edge N+1. Peak throughput is one beat per 2 cycles.
- add_a/add_b/add_ci change only on accept. They hold their last values in IDLE and HOLD.
- Chaining: in_first=1 overrides carry_q, even if the previous operation ended without in_last. A beat with in_first=0 after reset uses carry_q=0.
- A beat with in_first=1 and in_last=1 is a standalone 8-bit add.
- Carry-out of the final (in_last) beat appears on out_co only; it is not kept in carry_q.
- in_valid while busy (ISSUE, or HOLD without out_ready) is not accepted. The source must hold the beat.
- reset_L low mid-operation (ISSUE or HOLD): the beat in flight is discarded, state goes to IDLE and carry_q=0, all asynchronously.

Optional Feature:
- Macro SUM_RIZADO_OVF_EN.
- Defined: out_ovf is captured in ISSUE as (add_a[7]~^add_b[7]) & (add_a[7]^sum[7]), where sum is the corrected byte. It is held in HOLD.
- Undefined: out_ovf is tied 0 and no overflow logic is built. The port list is identical either way.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_HOLD=2'd2
  - width constant SUM_W=8
  - an 8-bit reverse function
- No sub-module; the ripple adder is instantiated by the parent and connected through the add_* ports.

Test Plan:
- Single beat: in_a=8'h3C, in_b=8'h0F, in_cin=0, first=last=1 -> two edges later out_valid=1, out_sum=8'h4B, out_co=0, out_last=1.
- 16-bit chain 16'h01FF+16'h0001:
  - beat 1 FF+01, first=1 -> out_sum=8'h00, out_co=1
  - beat 2 01+00, first=0, last=1 -> add_ci=1, out_sum=8'h02, out_co=0
- Bit order with SUM_BITREV=1 and the real adder: 8'h01+8'h00 -> add_s=8'h80, out_sum=8'h01. Repeat with 8'h0F+8'h00 -> out_sum=8'h0F.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> out_sum and out_valid stable, in_ready=0. On out_ready=1, a new beat is accepted the same cycle and add_a updates.
- Reset: drop reset_L during ISSUE of beat 1 of a chain -> out_valid=0 immediately. After release, beat with first=0, in_a=8'hFF, in_b=8'h01 -> add_ci=0, out_sum=8'h00, out_co=1.
- With SUM_RIZADO_OVF_EN: 8'h7F+8'h01 -> out_ovf=1, out_sum=8'h80. 8'hFF+8'h01 -> out_ovf=0, out_co=1.
